// File: rtl/pc_fetch_unit_if.sv
// ROM-side fetch bus: address out from the fetch unit, data and data-valid back from the ROM.
interface pc_fetch_unit_if #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32
);
  logic [PC_WIDTH-1:0]    pc_out;
  logic [INSTR_WIDTH-1:0] instr_in;
  logic                   instr_valid;

  modport master (output pc_out, input instr_in, input instr_valid);
  modport slave  (input pc_out, output instr_in, output instr_valid);
endinterface

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: PC register, IF/ID latch, trap/branch redirect, EPC capture
// and saturating stall/redirect counters.
module pc_fetch_unit #(
  parameter int                    PC_WIDTH     = 32,
  parameter int                    INSTR_WIDTH  = 32,
  parameter int unsigned           PC_STEP      = 1,
  parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = '0,
  parameter logic [PC_WIDTH-1:0]   TRAP_VECTOR  = PC_WIDTH'('h10),
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = '0,
  parameter int                    CNT_WIDTH    = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  pc_fetch_unit_if.master        rom,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  input  logic                   trap_req,
  output logic [INSTR_WIDTH-1:0] instr_ID,
  output logic [PC_WIDTH-1:0]    pc_ID,
  output logic                   valid_ID,
  output logic                   flush_out,
  output logic [PC_WIDTH-1:0]    epc_out,
  output logic [CNT_WIDTH-1:0]   stall_cnt,
  output logic [CNT_WIDTH-1:0]   redirect_cnt
);

  localparam logic [PC_WIDTH-1:0]  STEP    = PC_WIDTH'(PC_STEP);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    SEL_TRAP,
    SEL_BRANCH,
    SEL_STALL,
    SEL_BUBBLE,
    SEL_ADVANCE
  } sel_t;

  sel_t                   sel;
  logic [PC_WIDTH-1:0]    pc_q;
  logic [PC_WIDTH-1:0]    pc_next;
  logic [INSTR_WIDTH-1:0] instr_next;
  logic [PC_WIDTH-1:0]    pc_id_next;
  logic                   valid_next;
  logic [PC_WIDTH-1:0]    epc_next;
  logic                   stall_inc;
  logic                   redirect_inc;

  assign rom.pc_out = pc_q;
  assign flush_out  = branch_taken | trap_req;

  // Trap beats branch, branch beats stall, stall beats a ROM wait; a wait only inserts a bubble.
  always_comb begin
    sel = SEL_ADVANCE;
    if (trap_req)
      sel = SEL_TRAP;
    else if (branch_taken)
      sel = SEL_BRANCH;
    else if (stall)
      sel = SEL_STALL;
    else if (!rom.instr_valid)
      sel = SEL_BUBBLE;
  end

  always_comb begin
    pc_next      = pc_q;
    instr_next   = instr_ID;
    pc_id_next   = pc_ID;
    valid_next   = valid_ID;
    epc_next     = epc_out;
    stall_inc    = 1'b0;
    redirect_inc = 1'b0;
    unique case (sel)
      SEL_TRAP: begin
        pc_next      = TRAP_VECTOR;
        epc_next     = valid_ID ? pc_ID : pc_q;
        instr_next   = NOP_INSTR;
        pc_id_next   = '0;
        valid_next   = 1'b0;
        redirect_inc = 1'b1;
      end
      SEL_BRANCH: begin
        pc_next      = branch_target;
        instr_next   = NOP_INSTR;
        pc_id_next   = '0;
        valid_next   = 1'b0;
        redirect_inc = 1'b1;
      end
      SEL_STALL: begin
        stall_inc = 1'b1;
      end
      SEL_BUBBLE: begin
        instr_next = NOP_INSTR;
        valid_next = 1'b0;
      end
      SEL_ADVANCE: begin
        instr_next = rom.instr_in;
        pc_id_next = pc_q;
        valid_next = 1'b1;
        pc_next    = pc_q + STEP;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_VECTOR;
      instr_ID <= NOP_INSTR;
      pc_ID    <= '0;
      valid_ID <= 1'b0;
      epc_out  <= '0;
    end else begin
      pc_q     <= pc_next;
      instr_ID <= instr_next;
      pc_ID    <= pc_id_next;
      valid_ID <= valid_next;
      epc_out  <= epc_next;
    end
  end

  // Counters stick at all-ones rather than wrapping so long runs stay meaningful.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt    <= '0;
      redirect_cnt <= '0;
    end else begin
      if (stall_inc && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + 1'b1;
      if (redirect_inc && redirect_cnt != CNT_MAX)
        redirect_cnt <= redirect_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: a default-parameter instance and a narrow
// PC_WIDTH=4 / PC_STEP=4 / CNT_WIDTH=2 instance for wrap and saturation.
module tb_pc_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc_id;
    logic [31:0] valid;
    logic [31:0] epc;
    logic [31:0] scnt;
    logic [31:0] rcnt;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_a = 1'b0;
  logic        reset_b = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        trap_req = 1'b0;

  logic [31:0] instr_id_a, pc_id_a, epc_a;
  logic        valid_a, flush_a;
  logic [15:0] scnt_a, rcnt_a;

  logic [7:0]  instr_id_b;
  logic [3:0]  pc_id_b, epc_b;
  logic        valid_b, flush_b;
  logic [1:0]  scnt_b, rcnt_b;

  int checks = 0;
  int errors = 0;
  int step_a = 0;
  int step_b = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  pc_fetch_unit_if #(.PC_WIDTH(32), .INSTR_WIDTH(32)) rom_a();
  pc_fetch_unit_if #(.PC_WIDTH(4),  .INSTR_WIDTH(8))  rom_b();

  always #5 clock = ~clock;

  always_comb rom_a.instr_in = 32'hA000_0000 | rom_a.pc_out;
  always_comb rom_b.instr_in = {4'hB, rom_b.pc_out};

  pc_fetch_unit dut_a (
    .clock(clock), .reset(reset_a), .rom(rom_a),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .trap_req(trap_req), .instr_ID(instr_id_a), .pc_ID(pc_id_a), .valid_ID(valid_a),
    .flush_out(flush_a), .epc_out(epc_a), .stall_cnt(scnt_a), .redirect_cnt(rcnt_a)
  );

  pc_fetch_unit #(
    .PC_WIDTH(4), .INSTR_WIDTH(8), .PC_STEP(4), .RESET_VECTOR(4'h0),
    .TRAP_VECTOR(4'h4), .NOP_INSTR(8'h00), .CNT_WIDTH(2)
  ) dut_b (
    .clock(clock), .reset(reset_b), .rom(rom_b),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target[3:0]),
    .trap_req(trap_req), .instr_ID(instr_id_b), .pc_ID(pc_id_b), .valid_ID(valid_b),
    .flush_out(flush_b), .epc_out(epc_b), .stall_cnt(scnt_b), .redirect_cnt(rcnt_b)
  );

  function automatic exp_t mk(input logic [31:0] pc, instr, pc_id, valid, epc, scnt, rcnt);
    exp_t e;
    e.pc = pc; e.instr = instr; e.pc_id = pc_id; e.valid = valid;
    e.epc = epc; e.scnt = scnt; e.rcnt = rcnt;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkReset(input int which);
    if (which == 0) begin
      checkOutput("a.reset.pc",    rom_a.pc_out, 32'h0);
      checkOutput("a.reset.instr", instr_id_a,   32'h0);
      checkOutput("a.reset.pc_id", pc_id_a,      32'h0);
      checkOutput("a.reset.valid", 32'(valid_a), 32'h0);
      checkOutput("a.reset.epc",   epc_a,        32'h0);
      checkOutput("a.reset.scnt",  32'(scnt_a),  32'h0);
      checkOutput("a.reset.rcnt",  32'(rcnt_a),  32'h0);
    end else begin
      checkOutput("b.reset.pc",    32'(rom_b.pc_out), 32'h0);
      checkOutput("b.reset.instr", 32'(instr_id_b),   32'h0);
      checkOutput("b.reset.pc_id", 32'(pc_id_b),      32'h0);
      checkOutput("b.reset.valid", 32'(valid_b),      32'h0);
      checkOutput("b.reset.epc",   32'(epc_b),        32'h0);
      checkOutput("b.reset.scnt",  32'(scnt_b),       32'h0);
      checkOutput("b.reset.rcnt",  32'(rcnt_b),       32'h0);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the state expected after the next rising edge.
  task automatic applyStimulus(input int which, input bit st, input bit br, input logic [31:0] tgt,
                               input bit tr, input bit iv, input bit flush_exp, input exp_t e);
    @(negedge clock);
    stall = st; branch_taken = br; branch_target = tgt; trap_req = tr;
    if (which == 0) begin
      rom_a.instr_valid = iv;
      q_a.push_back(e);
    end else begin
      rom_b.instr_valid = iv;
      q_b.push_back(e);
    end
    #1;
    if (which == 0) checkOutput($sformatf("a.e%0d.flush", q_a.size() + step_a), 32'(flush_a), 32'(flush_exp));
    else            checkOutput($sformatf("b.e%0d.flush", q_b.size() + step_b), 32'(flush_b), 32'(flush_exp));
  endtask

  always begin
    exp_t e;
    @(posedge clock);
    #1;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      step_a++;
      checkOutput($sformatf("a.e%0d.pc", step_a),    rom_a.pc_out, e.pc);
      checkOutput($sformatf("a.e%0d.instr", step_a), instr_id_a,   e.instr);
      checkOutput($sformatf("a.e%0d.pc_id", step_a), pc_id_a,      e.pc_id);
      checkOutput($sformatf("a.e%0d.valid", step_a), 32'(valid_a), e.valid);
      checkOutput($sformatf("a.e%0d.epc", step_a),   epc_a,        e.epc);
      checkOutput($sformatf("a.e%0d.scnt", step_a),  32'(scnt_a),  e.scnt);
      checkOutput($sformatf("a.e%0d.rcnt", step_a),  32'(rcnt_a),  e.rcnt);
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      step_b++;
      checkOutput($sformatf("b.e%0d.pc", step_b),    32'(rom_b.pc_out), e.pc);
      checkOutput($sformatf("b.e%0d.instr", step_b), 32'(instr_id_b),   e.instr);
      checkOutput($sformatf("b.e%0d.pc_id", step_b), 32'(pc_id_b),      e.pc_id);
      checkOutput($sformatf("b.e%0d.valid", step_b), 32'(valid_b),      e.valid);
      checkOutput($sformatf("b.e%0d.epc", step_b),   32'(epc_b),        e.epc);
      checkOutput($sformatf("b.e%0d.scnt", step_b),  32'(scnt_b),       e.scnt);
      checkOutput($sformatf("b.e%0d.rcnt", step_b),  32'(rcnt_b),       e.rcnt);
    end
  end

  localparam logic [31:0] A = 32'hA000_0000;

  initial begin
    rom_a.instr_valid = 1'b1;
    rom_b.instr_valid = 1'b1;
    #12;
    checkReset(0);
    checkReset(1);

    // Main instance: sequential fetch, stall, trap+branch, branch+stall, ROM wait, trap with no valid ID.
    @(posedge clock); #2 reset_a = 1'b1;
    applyStimulus(0, 0, 0, 32'h0,  0, 1, 0, mk(1,  A|0, 0, 1, 0, 0, 0));
    applyStimulus(0, 0, 0, 32'h0,  0, 1, 0, mk(2,  A|1, 1, 1, 0, 0, 0));
    applyStimulus(0, 0, 0, 32'h0,  0, 1, 0, mk(3,  A|2, 2, 1, 0, 0, 0));
    applyStimulus(0, 1, 0, 32'h0,  0, 1, 0, mk(3,  A|2, 2, 1, 0, 1, 0));
    applyStimulus(0, 1, 0, 32'h0,  0, 0, 0, mk(3,  A|2, 2, 1, 0, 2, 0));
    applyStimulus(0, 0, 0, 32'h0,  0, 1, 0, mk(4,  A|3, 3, 1, 0, 2, 0));
    applyStimulus(0, 0, 0, 32'h0,  0, 1, 0, mk(5,  A|4, 4, 1, 0, 2, 0));
    applyStimulus(0, 0, 0, 32'h0,  0, 1, 0, mk(6,  A|5, 5, 1, 0, 2, 0));
    applyStimulus(0, 0, 0, 32'h0,  0, 1, 0, mk(7,  A|6, 6, 1, 0, 2, 0));
    applyStimulus(0, 0, 0, 32'h0,  0, 1, 0, mk(8,  A|7, 7, 1, 0, 2, 0));
    applyStimulus(0, 0, 1, 32'h40, 1, 1, 1, mk(16, 0,   0, 0, 7, 2, 1));
    applyStimulus(0, 0, 0, 32'h0,  0, 1, 0, mk(17, A|16, 16, 1, 7, 2, 1));
    applyStimulus(0, 1, 1, 32'h20, 0, 1, 1, mk(32, 0,   0, 0, 7, 2, 2));
    applyStimulus(0, 0, 0, 32'h0,  0, 1, 0, mk(33, A|32, 32, 1, 7, 2, 2));
    applyStimulus(0, 0, 1, 32'h8,  0, 0, 1, mk(8,  0,   0, 0, 7, 2, 3));
    applyStimulus(0, 0, 0, 32'h0,  0, 1, 0, mk(9,  A|8, 8, 1, 7, 2, 3));
    applyStimulus(0, 0, 0, 32'h0,  0, 0, 0, mk(9,  0,   8, 0, 7, 2, 3));
    applyStimulus(0, 0, 0, 32'h0,  0, 0, 0, mk(9,  0,   8, 0, 7, 2, 3));
    applyStimulus(0, 0, 0, 32'h0,  0, 0, 0, mk(9,  0,   8, 0, 7, 2, 3));
    applyStimulus(0, 0, 0, 32'h0,  0, 1, 0, mk(10, A|9, 9, 1, 7, 2, 3));
    applyStimulus(0, 0, 0, 32'h0,  0, 0, 0, mk(10, 0,   9, 0, 7, 2, 3));
    applyStimulus(0, 0, 0, 32'h0,  1, 0, 1, mk(16, 0,   0, 0, 10, 2, 4));
    applyStimulus(0, 1, 0, 32'h0,  0, 0, 0, mk(16, 0,   0, 0, 10, 3, 4));
    @(posedge clock); #3;
    reset_a = 1'b0;
    #1;
    checkReset(0);

    // Narrow instance: branch to 12, wrap on the next fetch, then six stalls saturate a 2-bit counter.
    @(posedge clock); #2 reset_b = 1'b1;
    applyStimulus(1, 0, 1, 32'hC, 0, 1, 1, mk(12, 0,     0,  0, 0, 0, 1));
    applyStimulus(1, 0, 0, 32'h0, 0, 1, 0, mk(0,  8'hBC, 12, 1, 0, 0, 1));
    applyStimulus(1, 1, 0, 32'h0, 0, 1, 0, mk(0,  8'hBC, 12, 1, 0, 1, 1));
    applyStimulus(1, 1, 0, 32'h0, 0, 1, 0, mk(0,  8'hBC, 12, 1, 0, 2, 1));
    applyStimulus(1, 1, 0, 32'h0, 0, 1, 0, mk(0,  8'hBC, 12, 1, 0, 3, 1));
    applyStimulus(1, 1, 0, 32'h0, 0, 1, 0, mk(0,  8'hBC, 12, 1, 0, 3, 1));
    applyStimulus(1, 1, 0, 32'h0, 0, 1, 0, mk(0,  8'hBC, 12, 1, 0, 3, 1));
    applyStimulus(1, 1, 0, 32'h0, 0, 1, 0, mk(0,  8'hBC, 12, 1, 0, 3, 1));
    @(posedge clock); #3;
    reset_b = 1'b0;
    #1;
    checkReset(1);

    for (int i = 0; i < 10 && (q_a.size() > 0 || q_b.size() > 0); i++) @(posedge clock);
    #2;
    checkOutput("scoreboard.drained", 32'(q_a.size() + q_b.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
